mdll_sel_ctrl: RTL

//  Parametrised, fully registered injection-select controller for the MDLL ring mux.

---
 rtl/mdll_sel_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mdll_sel_ctrl.sv
// Injection-select controller for the MDLL ring mux: owns the N/M sub-period counters,
// picks ring / divider tap / reference injection, and tracks missed references and lock.
module mdll_sel_ctrl #(
  parameter int N_W         = 4,
  parameter int M_W         = 2,
  parameter int MISS_W      = 8,
  parameter int LOCK_FRAMES = 4,
  parameter int N_DEF       = 4,
  parameter int M_DEF       = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [N_W-1:0]    n_cfg_i,
  input  logic [M_W-1:0]    m_cfg_i,
  input  logic              ref_vld_i,
  output logic [1:0]        sel_o,
  output logic [N_W-1:0]    n_cnt_o,
  output logic [M_W-1:0]    m_cnt_o,
  output logic              frame_done_o,
  output logic              locked_o,
  output logic [MISS_W-1:0] miss_cnt_o,
  output logic              cfg_err_o
);

  localparam int G_W = $clog2(LOCK_FRAMES + 1);
  localparam logic [1:0] SEL_RING = 2'b00;
  localparam logic [1:0] SEL_TAP  = 2'b10;
  localparam logic [1:0] SEL_INJ  = 2'b01;

  typedef enum logic {IDLE, RUN} state_e;

  state_e            state_q, state_d;
  logic [N_W-1:0]    nSh_q, nSh_d, nCnt_q, nCnt_d;
  logic [M_W-1:0]    mSh_q, mSh_d, mCnt_q, mCnt_d;
  logic [1:0]        sel_q, sel_d;
  logic              frameDone_q, frameDone_d;
  logic              locked_q, locked_d;
  logic [MISS_W-1:0] missCnt_q, missCnt_d;
  logic [G_W-1:0]    good_q, good_d;
  logic              cfgErr_q, cfgErr_d;

  logic cfgValid, nWrap, lastM, frameEnd;

  assign cfgValid = (n_cfg_i != '0) && (m_cfg_i != '0);
  assign nWrap    = (state_q == RUN) && (nCnt_q == nSh_q);
  assign lastM    = (mCnt_q == mSh_q);
  assign frameEnd = nWrap && lastM;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      nSh_q       <= N_W'(N_DEF);
      mSh_q       <= M_W'(M_DEF);
      nCnt_q      <= '0;
      mCnt_q      <= '0;
      sel_q       <= SEL_RING;
      frameDone_q <= 1'b0;
      locked_q    <= 1'b0;
      missCnt_q   <= '0;
      good_q      <= '0;
      cfgErr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      nSh_q       <= nSh_d;
      mSh_q       <= mSh_d;
      nCnt_q      <= nCnt_d;
      mCnt_q      <= mCnt_d;
      sel_q       <= sel_d;
      frameDone_q <= frameDone_d;
      locked_q    <= locked_d;
      missCnt_q   <= missCnt_d;
      good_q      <= good_d;
      cfgErr_q    <= cfgErr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en_i && cfgValid) state_d = RUN;
      RUN:     if (frameEnd && !en_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    nSh_d       = nSh_q;
    mSh_d       = mSh_q;
    nCnt_d      = nCnt_q;
    mCnt_d      = mCnt_q;
    sel_d       = sel_q;
    frameDone_d = 1'b0;
    locked_d    = locked_q;
    missCnt_d   = missCnt_q;
    good_d      = good_q;
    cfgErr_d    = cfgErr_q;
    case (state_q)
      IDLE: begin
        sel_d    = SEL_RING;
        nCnt_d   = '0;
        mCnt_d   = '0;
        locked_d = 1'b0;
        good_d   = '0;
        if (en_i) begin
          if (cfgValid) begin
            nSh_d    = n_cfg_i;
            mSh_d    = m_cfg_i;
            nCnt_d   = N_W'(1);
            mCnt_d   = M_W'(1);
            cfgErr_d = 1'b0;
          end else begin
            cfgErr_d = 1'b1;
          end
        end
      end
      RUN: begin
        nCnt_d = nWrap ? N_W'(1) : nCnt_q + N_W'(1);
        if (nWrap) mCnt_d = lastM ? M_W'(1) : mCnt_q + M_W'(1);
        if (nWrap && !lastM)        sel_d = SEL_TAP;
        else if (frameEnd)          sel_d = ref_vld_i ? SEL_INJ : SEL_RING;
        else if (mCnt_q == M_W'(1)) sel_d = SEL_RING;
        if (frameEnd) begin
          frameDone_d = 1'b1;
          if (ref_vld_i) begin
            if (good_q != G_W'(LOCK_FRAMES)) good_d = good_q + G_W'(1);
            locked_d = (good_d == G_W'(LOCK_FRAMES));
          end else begin
            if (missCnt_q != '1) missCnt_d = missCnt_q + MISS_W'(1);
            good_d   = '0;
            locked_d = 1'b0;
          end
          // Stopping only ever happens here, so the frame in flight always completes.
          if (en_i) begin
            if (cfgValid) begin
              nSh_d    = n_cfg_i;
              mSh_d    = m_cfg_i;
              cfgErr_d = 1'b0;
            end else begin
              cfgErr_d = 1'b1;
            end
          end else begin
            nCnt_d   = '0;
            mCnt_d   = '0;
            sel_d    = SEL_RING;
            locked_d = 1'b0;
            good_d   = '0;
          end
        end
      end
      default: ;
    endcase
  end

  assign sel_o        = sel_q;
  assign n_cnt_o      = nCnt_q;
  assign m_cnt_o      = mCnt_q;
  assign frame_done_o = frameDone_q;
  assign locked_o     = locked_q;
  assign miss_cnt_o   = missCnt_q;
  assign cfg_err_o    = cfgErr_q;

endmodule
